// File: rtl/bus_sync_hs_rx.sv
// bus_sync_hs_rx: receive side of a 4-phase req/ack CDC bus handshake.
// Synchronizes req and data, waits for a stable word, then delivers it on a valid/ready port.
module bus_sync_hs_rx #(
  parameter int DATAWTH   = 8,
  parameter int NUMSTGS   = 2,
  parameter int STABLECNT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_async,
  input  logic [DATAWTH-1:0] data_async,
  output logic               ack,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATAWTH-1:0] out_data,
  output logic               busy,
  output logic               err
);
  localparam int CW = $clog2(STABLECNT + 1);
  typedef enum logic [1:0] {IDLE, STABLE, HOLD, ACK} state_t;
  state_t state, state_nxt;
  logic [NUMSTGS-1:0] req_sync, fill;
  logic [NUMSTGS-1:0][DATAWTH-1:0] data_sync;
  logic [DATAWTH-1:0] data_s, data_q, out_data_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic req_s, req_d, eq, seen_low, seen_low_nxt, ack_nxt, valid_nxt, err_nxt;
  assign req_s  = req_sync[NUMSTGS-1];
  assign data_s = data_sync[NUMSTGS-1];
  assign eq     = data_s == data_q;
  assign busy   = state != IDLE;
  // fill marks when the req synchronizer holds real samples, so reset-cleared zeros
  // are never mistaken for the source lowering req
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_sync  <= '0;
      fill      <= '0;
      data_sync <= '0;
      data_q    <= '0;
      req_d     <= 1'b0;
      cnt       <= '0;
      seen_low  <= 1'b0;
      ack       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_sync  <= {req_sync[NUMSTGS-2:0], req_async};
      fill      <= {fill[NUMSTGS-2:0], 1'b1};
      data_sync <= {data_sync[NUMSTGS-2:0], data_async};
      data_q    <= data_s;
      req_d     <= req_s;
      cnt       <= cnt_nxt;
      seen_low  <= seen_low_nxt;
      ack       <= ack_nxt;
      out_valid <= valid_nxt;
      out_data  <= out_data_nxt;
      err       <= err_nxt;
    end
  end
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = !eq ? CW'(1) : (cnt == CW'(STABLECNT) ? cnt : cnt + CW'(1));
    seen_low_nxt = seen_low | (fill[NUMSTGS-1] & ~req_s);
    ack_nxt      = ack;
    valid_nxt    = out_valid;
    out_data_nxt = out_data;
    err_nxt      = 1'b0;
    case (state)
      IDLE: if (req_s && seen_low) begin
        state_nxt    = STABLE;
        cnt_nxt      = CW'(1);
        seen_low_nxt = 1'b0;
      end
      STABLE: if (!req_s) begin
        state_nxt = IDLE;
        err_nxt   = 1'b1;
      end else if (cnt == CW'(STABLECNT) && eq) begin
        out_data_nxt = data_s;
        valid_nxt    = 1'b1;
        state_nxt    = HOLD;
      end
      HOLD: begin
        err_nxt = req_d & ~req_s;
        if (out_valid && out_ready) begin
          valid_nxt = 1'b0;
          ack_nxt   = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: if (!req_s) begin
        ack_nxt   = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_bus_sync_hs_rx.sv
// tb_bus_sync_hs_rx: directed checks of the CDC handshake receiver with default parameters.
module tb_bus_sync_hs_rx;
  logic clk = 1'b0, rst = 1'b1, req_async = 1'b0, out_ready = 1'b0;
  logic [7:0] data_async = '0;
  logic ack, out_valid, busy, err;
  logic [7:0] out_data;
  int checks = 0, failures = 0;
  bus_sync_hs_rx dut (
    .clk(clk), .rst(rst), .req_async(req_async), .data_async(data_async), .ack(ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // waits at negedges until the selected output (0: out_valid, 1: ack) equals val
  task automatic wait_for(input int which, input logic val, input int max, output int n);
    n = 0;
    while (n < max && ((which == 0 ? out_valid : ack) !== val)) begin
      @(negedge clk);
      n++;
    end
  endtask
  int n, err_cnt, val_cnt, delivered, extra;
  logic err_seen, got;
  logic [7:0] w;
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    // single transfer
    data_async = 8'hA5; req_async = 1'b1; out_ready = 1'b1;
    wait_for(0, 1'b1, 20, n);
    chk("t1_latency", n, 5);
    chk("t1_data", out_data, 8'hA5);
    chk("t1_busy", busy, 1);
    @(negedge clk);
    chk("t1_valid_1cyc", out_valid, 0);
    chk("t1_ack", ack, 1);
    req_async = 1'b0;
    wait_for(1, 1'b0, 20, n);
    chk("t1_ack_fall", n, 3);
    chk("t1_idle", busy, 0);
    chk("t1_err", err, 0);
    repeat (2) @(negedge clk);
    // backpressure
    data_async = 8'h3C; req_async = 1'b1; out_ready = 1'b0;
    wait_for(0, 1'b1, 20, n);
    chk("t2_valid", n, 5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_hold_valid", out_valid, 1);
      chk("t2_hold_data", out_data, 8'h3C);
      chk("t2_hold_ack", ack, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_ack", ack, 1);
    chk("t2_valid_drop", out_valid, 0);
    req_async = 1'b0;
    wait_for(1, 1'b0, 20, n);
    chk("t2_ack_fall", n, 3);
    repeat (2) @(negedge clk);
    // unstable bus while req is high
    req_async = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_async = i[0] ? 8'hFF : 8'h00;
      @(negedge clk);
      chk("t3_no_capture", out_valid, 0);
    end
    data_async = 8'h5A;
    wait_for(0, 1'b1, 20, n);
    chk("t3_timeout", n < 20, 1);
    chk("t3_data", out_data, 8'h5A);
    @(negedge clk);
    req_async = 1'b0;
    wait_for(1, 1'b0, 20, n);
    chk("t3_ack_fall", n, 3);
    repeat (2) @(negedge clk);
    // early req drop
    data_async = 8'h11; req_async = 1'b1;
    @(negedge clk);
    req_async = 1'b0;
    err_cnt = 0; val_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      err_cnt += int'(err);
      val_cnt += int'(out_valid);
    end
    chk("t4_err_pulses", err_cnt, 1);
    chk("t4_no_valid", val_cnt, 0);
    chk("t4_idle", busy, 0);
    // async reset in HOLD
    data_async = 8'hEE; req_async = 1'b1; out_ready = 1'b0;
    wait_for(0, 1'b1, 20, n);
    chk("t5_hold", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_ack", ack, 0);
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    val_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      val_cnt += int'(out_valid | busy);
    end
    chk("t5_no_recapture", val_cnt, 0);
    req_async = 1'b0; data_async = 8'h77;
    repeat (4) @(negedge clk);
    req_async = 1'b1; out_ready = 1'b1;
    wait_for(0, 1'b1, 20, n);
    chk("t5_valid", n, 5);
    chk("t5_data", out_data, 8'h77);
    @(negedge clk);
    chk("t5_ack", ack, 1);
    req_async = 1'b0;
    wait_for(1, 1'b0, 20, n);
    chk("t5_ack_fall", n, 3);
    // back-to-back random words with random backpressure
    delivered = 0; extra = 0; err_seen = 1'b0;
    for (int k = 0; k < 16; k++) begin
      w = 8'($urandom_range(0, 255));
      data_async = w; req_async = 1'b1; got = 1'b0;
      for (int c = 0; c < 80 && !got; c++) begin
        @(negedge clk);
        err_seen |= err;
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          got = 1'b1;
          delivered++;
          chk("t6_data", out_data, w);
        end
      end
      wait_for(1, 1'b1, 20, n);
      if (n >= 20) chk("t6_ack_rise", n, 0);
      req_async = 1'b0;
      for (int c = 0; c < 20 && ack; c++) begin
        @(negedge clk);
        err_seen |= err;
        extra += int'(out_valid);
      end
      chk("t6_ack_fall", ack, 0);
      @(negedge clk);
    end
    chk("t6_delivered", delivered, 16);
    chk("t6_extra", extra, 0);
    chk("t6_err", err_seen, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
